// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and the baud divider calculation used by receiver and transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        WAIT_HIGH,
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

    localparam int         OS_RATE = 16;
    localparam logic [3:0] VOTE_A  = 4'd7;
    localparam logic [3:0] VOTE_B  = 4'd8;
    localparam logic [3:0] VOTE_C  = 4'd9;
    localparam logic [3:0] SC_LAST = 4'(OS_RATE - 1);

    // Rounded clocks per oversampling tick, never below one.
    function automatic int calc_div(input int clk_hz, input int baud);
        int d;
        d = (clk_hz + (baud * OS_RATE) / 2) / (baud * OS_RATE);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Byte-stream interface between the UART receiver and the frame parser.
// byte_valid is a one-cycle strobe with no back-pressure: data is valid in the
// strobe cycle and held until the next good byte; there is no ready signal.
interface uart_rx_os_if;
    logic       rxd;
    logic [7:0] data;
    logic       byte_valid;
    logic       frame_err;
    logic       busy;

    modport master (input rxd, output data, output byte_valid, output frame_err, output busy);
    modport slave  (output rxd, input data, input byte_valid, input frame_err, input busy);
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running divider emitting one tick every DIV clocks, with a synchronous
// clear so a receiver can phase-align ticks to a start edge.
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    output logic o_tick
);
    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampling 8N1 receiver: synchroniser, 3-sample majority vote,
// false-start rejection and framing-error strobe.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic         tclk,
    input  logic         rst_n,
    uart_rx_os_if.master bus,
    output rx_state_e    o_dbg_state
);
    localparam int DIV = calc_div(CLK_HZ, BAUD);

    logic       r_sync1, r_rxs;
    rx_state_e  r_state, w_state_n;
    logic [3:0] r_sc, w_sc_n;
    logic [3:0] r_hcnt, w_hcnt_n;
    logic [2:0] r_bit, w_bit_n;
    logic [7:0] r_shift, w_shift_n;
    logic [7:0] r_data, w_data_n;
    logic       r_bv, w_bv_n;
    logic       r_fe, w_fe_n;
    logic       r_s7, r_s8;
    logic       w_tick, w_clr, w_vote, w_vote_now, w_bit_end;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk    (tclk),
        .rst_n  (rst_n),
        .i_clr  (w_clr),
        .o_tick (w_tick)
    );

    assign w_vote     = (r_s7 & r_s8) | (r_s7 & r_rxs) | (r_s8 & r_rxs);
    assign w_vote_now = w_tick && (r_sc == VOTE_C);
    assign w_bit_end  = w_tick && (r_sc == SC_LAST);

    always_ff @(posedge tclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
            r_state <= WAIT_HIGH;
            r_sc    <= '0;
            r_hcnt  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_bv    <= 1'b0;
            r_fe    <= 1'b0;
            r_s7    <= 1'b1;
            r_s8    <= 1'b1;
        end else begin
            r_sync1 <= bus.rxd;
            r_rxs   <= r_sync1;
            r_state <= w_state_n;
            r_sc    <= w_sc_n;
            r_hcnt  <= w_hcnt_n;
            r_bit   <= w_bit_n;
            r_shift <= w_shift_n;
            r_data  <= w_data_n;
            r_bv    <= w_bv_n;
            r_fe    <= w_fe_n;
            if (w_tick && (r_sc == VOTE_A)) r_s7 <= r_rxs;
            if (w_tick && (r_sc == VOTE_B)) r_s8 <= r_rxs;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_sc_n    = w_tick ? (r_sc + 4'd1) : r_sc;
        w_hcnt_n  = r_hcnt;
        w_bit_n   = r_bit;
        w_shift_n = r_shift;
        w_data_n  = r_data;
        w_bv_n    = 1'b0;
        w_fe_n    = 1'b0;
        w_clr     = 1'b0;
        case (r_state)
            WAIT_HIGH: begin
                if (w_tick) begin
                    if (!r_rxs) begin
                        w_hcnt_n = '0;
                    end else if (r_hcnt == SC_LAST) begin
                        w_hcnt_n  = '0;
                        w_state_n = IDLE;
                    end else begin
                        w_hcnt_n = r_hcnt + 4'd1;
                    end
                end
            end
            IDLE: begin
                // Line is known idle here, so a low level is a start edge.
                if (!r_rxs) begin
                    w_clr     = 1'b1;
                    w_sc_n    = '0;
                    w_state_n = START;
                end
            end
            START: begin
                if (w_vote_now && w_vote) begin
                    w_state_n = IDLE;
                end else if (w_bit_end) begin
                    w_bit_n   = '0;
                    w_state_n = DATA;
                end
            end
            DATA: begin
                if (w_vote_now) w_shift_n = {w_vote, r_shift[7:1]};
                if (w_bit_end) begin
                    if (r_bit == 3'd7) w_state_n = STOP;
                    else               w_bit_n   = r_bit + 3'd1;
                end
            end
            STOP: begin
                // Leave at the vote, not the bit end, so a following start bit is caught.
                if (w_vote_now) begin
                    if (w_vote) begin
                        w_data_n  = r_shift;
                        w_bv_n    = 1'b1;
                        w_state_n = IDLE;
                    end else begin
                        w_fe_n    = 1'b1;
                        w_hcnt_n  = '0;
                        w_state_n = WAIT_HIGH;
                    end
                end
            end
            default: w_state_n = WAIT_HIGH;
        endcase
    end

    assign bus.data       = r_data;
    assign bus.byte_valid = r_bv;
    assign bus.frame_err  = r_fe;
    assign bus.busy       = (r_state == START) || (r_state == DATA) || (r_state == STOP);
    assign o_dbg_state    = r_state;

endmodule
